// File: rtl/image_sender.sv
// image_sender: streams one RGB frame from a frame memory to a detector.
//
// A frame is requested with start while idle. The block reads the frame
// memory in raster order (1-cycle read latency), presents every pixel on a
// registered bus for exactly one cycle with no gaps, and flags the frame
// start with a one-cycle enable pulse. It then waits for the detector's
// finish flag to rise (bounded by TIMEOUT cycles) and fall again before
// reporting success.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               frame request, honoured only in IDLE
//   mem_rd, mem_addr    frame-memory read strobe and raster address
//   mem_R/G/B           frame-memory read data, valid 1 cycle after mem_rd
//   image_out_R/G/B     registered pixel bus to the detector
//   enable              one-cycle frame-start pulse
//   finish              detector busy-sending flag
//   busy                high whenever the FSM is not in IDLE
//   done                one-cycle pulse on a completed frame
//   timeout_err         one-cycle pulse when finish never arrives
//   frame_count         number of completed frames (wraps)
module image_sender #(
   parameter int WIDTH       = 256,
   parameter int DEPTH       = 256,
   parameter int COLOR_DEPTH = 8,
   parameter int TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   mem_rd,
   output logic [15:0]            mem_addr,
   input  logic [COLOR_DEPTH-1:0] mem_R,
   input  logic [COLOR_DEPTH-1:0] mem_G,
   input  logic [COLOR_DEPTH-1:0] mem_B,
   output logic [COLOR_DEPTH-1:0] image_out_R,
   output logic [COLOR_DEPTH-1:0] image_out_G,
   output logic [COLOR_DEPTH-1:0] image_out_B,
   output logic                   enable,
   input  logic                   finish,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout_err,
   output logic [15:0]            frame_count
);

   localparam int NPIX = WIDTH * DEPTH;
   localparam int PW   = $clog2(NPIX + 1);
   localparam int XW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int YW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW   = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, PREFETCH, ARM, STREAM, WAIT_FIN, WAIT_LOW
   } state_t;

   state_t                 state_q;
   logic [XW-1:0]          posx_q, posx_d;
   logic [YW-1:0]          posy_q, posy_d;
   logic [15:0]            mem_addr_q, mem_addr_d;
   logic                   mem_rd_q;
   logic [PW-1:0]          pix_q;
   logic [TW-1:0]          tmo_q;
   logic [COLOR_DEPTH-1:0] r_q, g_q, b_q;
   logic                   enable_q, busy_q, done_q, tmo_err_q;
   logic [15:0]            frame_count_q;
   logic                   last_rd, more_rd;

   // Next raster position and its linear address.
   always_comb begin
      posx_d = posx_q;
      posy_d = posy_q;
      if (posx_q == XW'(WIDTH - 1)) begin
         posx_d = '0;
         posy_d = posy_q + 1'b1;
      end else begin
         posx_d = posx_q + 1'b1;
      end
      mem_addr_d = 16'(32'(posy_d) * WIDTH + 32'(posx_d));
      last_rd    = (posx_q == XW'(WIDTH - 1)) && (posy_q == YW'(DEPTH - 1));
      more_rd    = mem_rd_q && !last_rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         posx_q        <= '0;
         posy_q        <= '0;
         mem_addr_q    <= '0;
         mem_rd_q      <= 1'b0;
         pix_q         <= '0;
         tmo_q         <= '0;
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
         enable_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         tmo_err_q     <= 1'b0;
         frame_count_q <= '0;
      end else begin
         enable_q  <= 1'b0;
         done_q    <= 1'b0;
         tmo_err_q <= 1'b0;

         // Reads run one address ahead of the pixel bus, so issuing starts
         // in PREFETCH and stops right after the last raster address.
         if (state_q == PREFETCH || state_q == ARM || state_q == STREAM) begin
            if (more_rd) begin
               posx_q     <= posx_d;
               posy_q     <= posy_d;
               mem_addr_q <= mem_addr_d;
            end else begin
               mem_rd_q   <= 1'b0;
               mem_addr_q <= '0;
            end
         end

         case (state_q)
            IDLE: begin
               r_q <= '0;
               g_q <= '0;
               b_q <= '0;
               // A start coinciding with the done pulse belongs to the
               // previous handshake and is dropped.
               if (start && !done_q) begin
                  state_q    <= PREFETCH;
                  busy_q     <= 1'b1;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= '0;
                  posx_q     <= '0;
                  posy_q     <= '0;
                  pix_q      <= '0;
               end
            end
            PREFETCH: begin
               state_q  <= ARM;
               enable_q <= 1'b1;
            end
            ARM: begin
               r_q     <= mem_R;
               g_q     <= mem_G;
               b_q     <= mem_B;
               state_q <= STREAM;
            end
            STREAM: begin
               if (pix_q == PW'(NPIX - 1)) begin
                  r_q     <= '0;
                  g_q     <= '0;
                  b_q     <= '0;
                  tmo_q   <= '0;
                  state_q <= WAIT_FIN;
               end else begin
                  r_q   <= mem_R;
                  g_q   <= mem_G;
                  b_q   <= mem_B;
                  pix_q <= pix_q + 1'b1;
               end
            end
            WAIT_FIN: begin
               if (finish) begin
                  state_q <= WAIT_LOW;
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  tmo_err_q <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            WAIT_LOW: begin
               if (!finish) begin
                  state_q       <= IDLE;
                  busy_q        <= 1'b0;
                  done_q        <= 1'b1;
                  frame_count_q <= frame_count_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_rd      = mem_rd_q;
   assign mem_addr    = mem_addr_q;
   assign image_out_R = r_q;
   assign image_out_G = g_q;
   assign image_out_B = b_q;
   assign enable      = enable_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = tmo_err_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_image_sender.sv
// Directed bench for image_sender with WIDTH=4, DEPTH=2, TIMEOUT=8.
// Memory word k holds R=k, G=k+16, B=k+32. Each frame is recorded as a
// NC-cycle trace sampled on the falling edge (cycle 0 = cycle start is
// driven); scenario tasks compare the trace against hand-derived values:
// cycle 1 PREFETCH, cycle 2 ARM, cycles 3..10 pixels 0..7, cycle 11 WAIT_FIN.
module tb_image_sender;

   localparam int W  = 4;
   localparam int D  = 2;
   localparam int CD = 8;
   localparam int TO = 8;
   localparam int NC = 40;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          finish = 1'b0;
   logic          mem_rd;
   logic [15:0]   mem_addr;
   logic [CD-1:0] mem_R = '0, mem_G = '0, mem_B = '0;
   logic [CD-1:0] image_out_R, image_out_G, image_out_B;
   logic          enable, busy, done, timeout_err;
   logic [15:0]   frame_count;

   int errors = 0;
   int checks = 0;
   int exp_fc = 0;

   logic [CD-1:0] tr_R [NC];
   logic [CD-1:0] tr_G [NC];
   logic [CD-1:0] tr_B [NC];
   logic          tr_en [NC];
   logic          tr_rd [NC];
   logic          tr_done [NC];
   logic          tr_tmo [NC];
   logic          tr_busy [NC];
   logic [15:0]   tr_addr [NC];

   image_sender #(
      .WIDTH(W), .DEPTH(D), .COLOR_DEPTH(CD), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_R(mem_R), .mem_G(mem_G), .mem_B(mem_B),
      .image_out_R(image_out_R), .image_out_G(image_out_G), .image_out_B(image_out_B),
      .enable(enable), .finish(finish), .busy(busy), .done(done),
      .timeout_err(timeout_err), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // Frame memory with 1-cycle read latency.
   logic [7:0] a8;
   assign a8 = mem_addr[7:0];
   always @(posedge clk) begin
      if (mem_rd) begin
         mem_R <= a8;
         mem_G <= a8 + 8'd16;
         mem_B <= a8 + 8'd32;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Runs NC cycles: start at cycle 0 (and at s1/s2), finish high for
   // cycles [fin_at, fin_at+fin_len).
   task automatic drive_frame(input int fin_at, input int fin_len, input int s1, input int s2);
      for (int c = 0; c < NC; c++) begin
         @(negedge clk);
         tr_R[c]    = image_out_R;
         tr_G[c]    = image_out_G;
         tr_B[c]    = image_out_B;
         tr_en[c]   = enable;
         tr_rd[c]   = mem_rd;
         tr_addr[c] = mem_addr;
         tr_done[c] = done;
         tr_tmo[c]  = timeout_err;
         tr_busy[c] = busy;
         start  = (c == 0) || (c == s1) || (c == s2);
         finish = (c >= fin_at) && (c < fin_at + fin_len);
      end
      start  = 1'b0;
      finish = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({enable, mem_rd, busy, done, timeout_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000", {enable, mem_rd, busy, done, timeout_err});
      end
      checks++;
      if (mem_addr !== 16'd0) begin
         errors++;
         $display("FAIL reset_addr: got %0d expected 0", mem_addr);
      end
      checks++;
      if ({image_out_R, image_out_G, image_out_B} !== 24'd0) begin
         errors++;
         $display("FAIL reset_pix: got %h expected 0", {image_out_R, image_out_G, image_out_B});
      end
      checks++;
      if (frame_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_fc: got %0d expected 0", frame_count);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_timeout;
      int n_tmo, n_done;
      drive_frame(-1, 0, -1, -1);
      n_tmo = 0; n_done = 0;
      for (int c = 0; c < NC; c++) begin
         n_tmo  += int'(tr_tmo[c]);
         n_done += int'(tr_done[c]);
      end
      checks++;
      if (tr_tmo[19] !== 1'b1 || n_tmo != 1) begin
         errors++;
         $display("FAIL timeout_pulse: got at19=%b count=%0d expected at19=1 count=1", tr_tmo[19], n_tmo);
      end
      checks++;
      if (tr_busy[18] !== 1'b1 || tr_busy[19] !== 1'b0 || tr_busy[20] !== 1'b0) begin
         errors++;
         $display("FAIL timeout_busy: got %b%b%b expected 100", tr_busy[18], tr_busy[19], tr_busy[20]);
      end
      checks++;
      if (n_done != 0 || frame_count !== 16'd0) begin
         errors++;
         $display("FAIL timeout_fc: got done=%0d fc=%0d expected done=0 fc=0", n_done, frame_count);
      end
   endtask

   task automatic test_frame;
      int n_en, n_done;
      drive_frame(13, 8, -1, -1);
      exp_fc++;
      n_en = 0; n_done = 0;
      for (int c = 0; c < NC; c++) begin
         n_en   += int'(tr_en[c]);
         n_done += int'(tr_done[c]);
      end
      checks++;
      if (tr_en[2] !== 1'b1 || n_en != 1) begin
         errors++;
         $display("FAIL frame_enable: got at2=%b count=%0d expected at2=1 count=1", tr_en[2], n_en);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (tr_R[3+i] !== 8'(i) || tr_G[3+i] !== 8'(i + 16) || tr_B[3+i] !== 8'(i + 32)) begin
            errors++;
            $display("FAIL frame_pix%0d: got R=%0d G=%0d B=%0d expected R=%0d G=%0d B=%0d",
                     i, tr_R[3+i], tr_G[3+i], tr_B[3+i], i, i + 16, i + 32);
         end
      end
      checks++;
      if (tr_R[2] !== 8'd0 || tr_R[11] !== 8'd0 || tr_G[11] !== 8'd0) begin
         errors++;
         $display("FAIL frame_pix_edges: got arm=%0d after=%0d expected 0 0", tr_R[2], tr_R[11]);
      end
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if (tr_rd[c] !== 1'b1 || tr_addr[c] !== 16'(c - 1)) begin
            errors++;
            $display("FAIL frame_addr%0d: got rd=%b addr=%0d expected rd=1 addr=%0d", c, tr_rd[c], tr_addr[c], c - 1);
         end
      end
      checks++;
      if (tr_rd[9] !== 1'b0 || tr_rd[11] !== 1'b0) begin
         errors++;
         $display("FAIL frame_rd_stop: got %b%b expected 00", tr_rd[9], tr_rd[11]);
      end
      checks++;
      if (tr_done[22] !== 1'b1 || n_done != 1) begin
         errors++;
         $display("FAIL frame_done: got at22=%b count=%0d expected at22=1 count=1", tr_done[22], n_done);
      end
      checks++;
      if (frame_count !== 16'(exp_fc)) begin
         errors++;
         $display("FAIL frame_fc: got %0d expected %0d", frame_count, exp_fc);
      end
   endtask

   task automatic test_start_ignored;
      int n_rd, n_en, n_done, hits;
      drive_frame(13, 8, 5, 12);
      exp_fc++;
      n_rd = 0; n_en = 0; n_done = 0;
      for (int c = 0; c < NC; c++) begin
         n_rd   += int'(tr_rd[c]);
         n_en   += int'(tr_en[c]);
         n_done += int'(tr_done[c]);
      end
      checks++;
      if (n_rd != 8 || n_en != 1 || n_done != 1) begin
         errors++;
         $display("FAIL ignore_counts: got rd=%0d en=%0d done=%0d expected 8 1 1", n_rd, n_en, n_done);
      end
      for (int k = 0; k < 8; k++) begin
         hits = 0;
         for (int c = 0; c < NC; c++)
            if (tr_rd[c] === 1'b1 && tr_addr[c] === 16'(k)) hits++;
         checks++;
         if (hits != 1) begin
            errors++;
            $display("FAIL ignore_addr%0d: got %0d reads expected 1", k, hits);
         end
      end
      checks++;
      if (tr_busy[NC-1] !== 1'b0 || frame_count !== 16'(exp_fc)) begin
         errors++;
         $display("FAIL ignore_end: got busy=%b fc=%0d expected busy=0 fc=%0d", tr_busy[NC-1], frame_count, exp_fc);
      end
   endtask

   task automatic test_done_start;
      int n_rd_late;
      drive_frame(13, 8, 22, -1);
      exp_fc++;
      n_rd_late = 0;
      for (int c = 22; c < NC; c++) n_rd_late += int'(tr_rd[c]);
      checks++;
      if (tr_done[22] !== 1'b1 || tr_busy[23] !== 1'b0 || n_rd_late != 0) begin
         errors++;
         $display("FAIL done_start: got done=%b busy23=%b late_rd=%0d expected 1 0 0",
                  tr_done[22], tr_busy[23], n_rd_late);
      end
      checks++;
      if (frame_count !== 16'(exp_fc)) begin
         errors++;
         $display("FAIL done_start_fc: got %0d expected %0d", frame_count, exp_fc);
      end
   endtask

   task automatic test_reset_mid_stream;
      int n_done;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (image_out_R !== 8'd3) begin
         errors++;
         $display("FAIL abort_pre: got R=%0d expected 3", image_out_R);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({image_out_R, image_out_G, image_out_B} !== 24'd0 ||
          {enable, mem_rd, busy, done, timeout_err} !== 5'b0 ||
          mem_addr !== 16'd0 || frame_count !== 16'd0) begin
         errors++;
         $display("FAIL abort_outputs: got pix=%h ctrl=%b addr=%0d fc=%0d expected all 0",
                  {image_out_R, image_out_G, image_out_B}, {enable, mem_rd, busy, done, timeout_err},
                  mem_addr, frame_count);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_fc = 0;
      drive_frame(13, 8, -1, -1);
      exp_fc++;
      n_done = 0;
      for (int c = 0; c < NC; c++) n_done += int'(tr_done[c]);
      checks++;
      if (tr_rd[1] !== 1'b1 || tr_addr[1] !== 16'd0 || tr_R[3] !== 8'd0 || tr_G[3] !== 8'd16) begin
         errors++;
         $display("FAIL abort_restart: got addr=%0d R=%0d G=%0d expected 0 0 16", tr_addr[1], tr_R[3], tr_G[3]);
      end
      checks++;
      if (n_done != 1 || frame_count !== 16'(exp_fc)) begin
         errors++;
         $display("FAIL abort_fc: got done=%0d fc=%0d expected 1 %0d", n_done, frame_count, exp_fc);
      end
   endtask

   task automatic test_back_to_back;
      int n_en, n_nz;
      for (int f = 0; f < 3; f++) begin
         drive_frame(13, 8, -1, -1);
         exp_fc++;
         n_en = 0; n_nz = 0;
         for (int c = 0; c < NC; c++) begin
            n_en += int'(tr_en[c]);
            if ((c < 3 || c > 10) && {tr_R[c], tr_G[c], tr_B[c]} !== 24'd0) n_nz++;
         end
         checks++;
         if (n_en != 1 || n_nz != 0 || tr_R[10] !== 8'd7) begin
            errors++;
            $display("FAIL b2b_frame%0d: got en=%0d nonzero=%0d last=%0d expected 1 0 7", f, n_en, n_nz, tr_R[10]);
         end
      end
      checks++;
      if (frame_count !== 16'(exp_fc)) begin
         errors++;
         $display("FAIL b2b_fc: got %0d expected %0d", frame_count, exp_fc);
      end
   endtask

   task automatic test_wrap;
      @(negedge clk);
      force dut.frame_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count_q;
      @(negedge clk);
      checks++;
      if (frame_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_preload: got %0d expected 65535", frame_count);
      end
      drive_frame(13, 8, -1, -1);
      checks++;
      if (tr_done[22] !== 1'b1 || frame_count !== 16'd0) begin
         errors++;
         $display("FAIL wrap_fc: got done=%b fc=%0d expected done=1 fc=0", tr_done[22], frame_count);
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_frame();
      test_start_ignored();
      test_done_start();
      test_reset_mid_stream();
      test_back_to_back();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
